// File: rtl/perceptron_pkg.sv
// Shared encodings for the perceptron stream source: weight-load strobes and FSM states.
package perceptron_pkg;

    localparam logic [1:0] WEN_NONE = 2'b00;
    localparam logic [1:0] WEN_W0   = 2'b01;
    localparam logic [1:0] WEN_W1   = 2'b10;
    localparam logic [1:0] WEN_B    = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WL0    = 3'd1,
        ST_WL1    = 3'd2,
        ST_WLB    = 3'd3,
        ST_GAP    = 3'd4,
        ST_STREAM = 3'd5,
        ST_DONE   = 3'd6
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock sample FIFO: head word is always visible on data_o, no write-through.
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push, do_pop;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign data_o  = mem_q[rd_ptr_q];

    // A push is refused when full even if a pop frees a slot in the same cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_q <= count_q + CNT_ONE;
            else if (do_pop && !do_push) count_q <= count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/perceptron_stream_src.sv
// Loads perceptron weights/bias over W1W0b_en, then streams buffered samples with val/rdy.
module perceptron_stream_src
    import perceptron_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_samples_i,
    input  logic [DATA_W-1:0] w0_i,
    input  logic [DATA_W-1:0] w1_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [1:0]        W1W0b_en_o,
    output logic [DATA_W-1:0] wdata_o,
    input  logic              in_val_i,
    output logic              in_rdy_o,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              val_o,
    input  logic              rdy_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  sent_cnt_o
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e            state_q;
    logic [1:0]        wen_q;
    logic [DATA_W-1:0] wdata_q;
    logic              done_q;
    logic [CNT_W-1:0]  sent_cnt_q, sent_cnt_d;
    logic [CNT_W-1:0]  num_q;
    logic [DATA_W-1:0] w1_q, b_q;

    logic fifo_full, fifo_empty, fifo_push, fifo_pop, start_acc;

    assign in_rdy_o  = !fifo_full && !reset;
    assign fifo_push = in_val_i && in_rdy_o;
    assign val_o     = (state_q == ST_STREAM) && !fifo_empty && !reset;
    assign fifo_pop  = val_o && rdy_i;
    assign start_acc = (state_q == ST_IDLE) && start_i;

    assign sent_cnt_d = sent_cnt_q + CNT_ONE;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (in_data_i),
        .data_o  (data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Run parameters are plain data: captured on an accepted start, never reset.
    always_ff @(posedge clk) begin
        if (start_acc) begin
            num_q <= num_samples_i;
            w1_q  <= w1_i;
            b_q   <= b_i;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            wen_q      <= WEN_NONE;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            sent_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start_i) begin
                        sent_cnt_q <= '0;
                        if (num_samples_i != '0) begin
                            state_q <= ST_WL0;
                            wen_q   <= WEN_W0;
                            wdata_q <= w0_i;
                        end else begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_WL0: begin
                    state_q <= ST_WL1;
                    wen_q   <= WEN_W1;
                    wdata_q <= w1_q;
                end
                ST_WL1: begin
                    state_q <= ST_WLB;
                    wen_q   <= WEN_B;
                    wdata_q <= b_q;
                end
                ST_WLB: begin
                    state_q <= ST_GAP;
                    wen_q   <= WEN_NONE;
                    wdata_q <= '0;
                end
                ST_GAP: begin
                    state_q <= ST_STREAM;
                end
                ST_STREAM: begin
                    if (fifo_pop) begin
                        sent_cnt_q <= sent_cnt_d;
                        if (sent_cnt_d == num_q) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    wen_q   <= WEN_NONE;
                    wdata_q <= '0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign W1W0b_en_o = wen_q;
    assign wdata_o    = wdata_q;
    assign done_o     = done_q;
    assign busy_o     = (state_q != ST_IDLE);
    assign sent_cnt_o = sent_cnt_q;

endmodule
